traffic_phase_ctrl: RTL and testbench
=====================================

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_APP, 4, number of approaches (2..8)
- GREEN_MIN, 20, minimum green duration in ticks
- GREEN_MAX, 60, maximum green duration in ticks when other demand exists
- YELLOW_T, 5, yellow duration in ticks
- ALLRED_T, 2, all-red clearance duration in ticks
- CNT_W, 8, timer width; all durations SHALL fit in CNT_W bits
REQ-002 The block SHALL have these ports (IW = clog2(NUM_APP)):
- Clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle timebase pulse
- car_det  in  NUM_APP  per-approach vehicle detect, level or pulse
- amb_req  in  1  emergency preemption request
- amb_dir  in  IW  approach requested by the emergency vehicle
- red / yellow / green  out  NUM_APP each  lamp drives, one bit per approach
- phase  out  IW  approach currently served
- st  out  1  one-cycle pulse on every state change
- amb_active  out  1  high while preemption holds green on amb_dir

Function
REQ-003 The FSM SHALL have three states: GREEN, YELLOW and ALLRED, all acting on the approach given by phase.
REQ-004 Lamp outputs SHALL be Moore decodes of the registered state and phase:
- green[phase] high in GREEN; yellow[phase] high in YELLOW
- all other bits of red high; in ALLRED every red bit high
- exactly one lamp high per approach in every cycle
REQ-005 The timer SHALL clear to 0 on every state change, increment on tick otherwise, and saturate at all-ones.
REQ-006 A car_det bit SHALL set a sticky demand bit; demand[phase] SHALL clear on entry to GREEN for that phase, and car_det[phase] SHALL be ignored while in GREEN.
REQ-007 GREEN to YELLOW SHALL occur when any of these holds:
- amb_req is high and amb_dir != phase, regardless of GREEN_MIN
- amb_req is low, other demand exists and timer >= GREEN_MIN
REQ-008 With no demand on another approach and no preemption, GREEN SHALL hold indefinitely; GREEN_MAX SHALL cap green only while competing demand exists, and the REQ-007 GREEN_MIN condition is always met by then.
REQ-009 While amb_req is high and amb_dir == phase in GREEN, the FSM SHALL hold GREEN and amb_active SHALL be 1; amb_active SHALL be 0 otherwise.
REQ-010 YELLOW SHALL go to ALLRED when timer == YELLOW_T, and ALLRED SHALL go to GREEN when timer == ALLRED_T.
REQ-011 The next phase SHALL be selected on ALLRED exit:
- amb_dir if amb_req is high at that cycle
- otherwise the first approach with demand after phase in round-robin order, wrapping NUM_APP-1 to 0
- otherwise phase+1, wrapping
REQ-012 A preemption arriving in YELLOW or ALLRED SHALL NOT abort clearance; it SHALL take effect at ALLRED exit.
REQ-013 If amb_req drops before ALLRED exit, normal selection per REQ-011 SHALL apply.
REQ-014 st SHALL pulse high for exactly one cycle in the cycle after each state or phase change.
REQ-015 If tick and a state change coincide, the timer SHALL clear and the tick SHALL be discarded.

Reset
REQ-016 When reset is sampled high, the block SHALL enter this state on the next edge: state=GREEN, phase=0, timer=0, demand=0, st=1, amb_active=0, green=0...01, red=1...10, yellow=0.
REQ-017 A reset mid-sequence SHALL override every pending transition and preemption.

Verification
REQ-018 The bench SHALL cover these directed scenarios (NUM_APP=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1, tick every cycle):
- Reset released, no car_det for 50 cycles -> green=0001 throughout, st high only in the cycle after reset.
- car_det=0100 at cycle 1 -> YELLOW on approach 0 once timer reaches 3, ALLRED after 2 ticks, then green=0100, phase=2, st pulses at each change.
- demand=1010 from approach 0 -> service order 1 then 3 then back to 0 (wrap).
- amb_req=1, amb_dir=3 in GREEN phase 0 with timer=0 -> immediate YELLOW, ALLRED, then green=1000 held while amb_req=1 with amb_active=1.
- amb_req pulse during YELLOW that drops before ALLRED exit -> yellow and all-red run full length, round-robin selection, amb_active stays 0.
- reset asserted in YELLOW of phase 2 -> next cycle green=0001, phase=0, timer=0, demand cleared.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// Single-intersection traffic phase controller: GREEN -> YELLOW -> ALLRED per approach,
// round-robin service of sticky vehicle demand, with emergency-vehicle preemption.
module traffic_phase_ctrl #(
  parameter int NUM_APP   = 4,
  parameter int GREEN_MIN = 20,
  parameter int GREEN_MAX = 60,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8,
  localparam int IW       = $clog2(NUM_APP)
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [NUM_APP-1:0] car_det,
  input  logic               amb_req,
  input  logic [IW-1:0]      amb_dir,
  output logic [NUM_APP-1:0] red,
  output logic [NUM_APP-1:0] yellow,
  output logic [NUM_APP-1:0] green,
  output logic [IW-1:0]      phase,
  output logic               st,
  output logic               amb_active
);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] GREEN_MIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GREEN_MAX_C = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YELLOW_C    = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLRED_C    = CNT_W'(ALLRED_T);

  state_e             state_q, state_d;
  logic [IW-1:0]      phase_q, phase_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [NUM_APP-1:0] demand_q, demand_d;
  logic               st_q, st_d;
  logic               amb_active_q, amb_active_d;

  logic [NUM_APP-1:0] phase_sel;
  logic [NUM_APP-1:0] entry_sel;
  logic               other_demand;
  logic               changed;
  logic [IW-1:0]      rr_phase;

  // Approach index (p + k) modulo NUM_APP, valid for non-power-of-two NUM_APP.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(k);
    if (s >= (IW+1)'(NUM_APP)) s = s - (IW+1)'(NUM_APP);
    return s[IW-1:0];
  endfunction

  assign phase_sel    = NUM_APP'(1) << phase_q;
  assign entry_sel    = NUM_APP'(1) << phase_d;
  assign other_demand = |(demand_q & ~phase_sel);

  // Nearest waiting approach after the current one; descending scan lets the closest win.
  always_comb begin
    rr_phase = wrap_add(phase_q, 1);
    for (int k = NUM_APP - 1; k >= 1; k--) begin
      if (demand_q[wrap_add(phase_q, k)]) rr_phase = wrap_add(phase_q, k);
    end
  end

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    phase_d = phase_q;

    unique case (state_q)
      S_GREEN: begin
        if (amb_req) begin
          if (amb_dir != phase_q) state_d = S_YELLOW;
        end else if (other_demand &&
                     ((timer_q >= GREEN_MIN_C) || (timer_q >= GREEN_MAX_C))) begin
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer_q == YELLOW_C) state_d = S_ALLRED;
      end
      S_ALLRED: begin
        if (timer_q == ALLRED_C) begin
          state_d = S_GREEN;
          phase_d = amb_req ? amb_dir : rr_phase;
        end
      end
      default: state_d = S_GREEN;
    endcase

    changed = (state_d != state_q) || (phase_d != phase_q);

    // A tick coinciding with a state change is dropped: the new state starts at zero.
    if (changed)                    timer_d = '0;
    else if (tick && timer_q != '1) timer_d = timer_q + CNT_W'(1);
    else                            timer_d = timer_q;

    // The served approach cannot re-arm its own demand while it is green.
    demand_d = demand_q | (car_det & ((state_q == S_GREEN) ? ~phase_sel : '1));
    if (state_d == S_GREEN && state_q != S_GREEN) demand_d = demand_d & ~entry_sel;

    st_d         = changed;
    amb_active_d = (state_d == S_GREEN) && amb_req && (amb_dir == phase_d);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= S_GREEN;
      phase_q      <= '0;
      timer_q      <= '0;
      demand_q     <= '0;
      st_q         <= 1'b1;
      amb_active_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q      <= state_d;
      phase_q      <= phase_d;
      timer_q      <= timer_d;
      demand_q     <= demand_d;
      st_q         <= st_d;
      amb_active_q <= amb_active_d;
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    red    = ~phase_sel;
    unique case (state_q)
      S_GREEN:  green  = phase_sel;
      S_YELLOW: yellow = phase_sel;
      default:  red    = '1;
    endcase
  end

  assign phase      = phase_q;
  assign st         = st_q;
  assign amb_active = amb_active_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: a cycle model pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares; directed scenarios add timing checks.
module tb_traffic_phase_ctrl;

  localparam int NUM_APP   = 4;
  localparam int GREEN_MIN = 3;
  localparam int GREEN_MAX = 6;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int CNT_W     = 8;

  logic       Clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] car_det;
  logic       amb_req;
  logic [1:0] amb_dir;
  logic [3:0] red, yellow, green;
  logic [1:0] phase;
  logic       st, amb_active;

  always #5 Clk = ~Clk;

  traffic_phase_ctrl #(
    .NUM_APP  (NUM_APP),
    .GREEN_MIN(GREEN_MIN),
    .GREEN_MAX(GREEN_MAX),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .tick      (tick),
    .car_det   (car_det),
    .amb_req   (amb_req),
    .amb_dir   (amb_dir),
    .red       (red),
    .yellow    (yellow),
    .green     (green),
    .phase     (phase),
    .st        (st),
    .amb_active(amb_active)
  );

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] yellow;
    logic [3:0] green;
    logic [1:0] phase;
    logic       st;
    logic       amb;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: states 0=GREEN 1=YELLOW 2=ALLRED, evaluated on the same edge as the DUT.
  int         m_state, m_phase, m_timer;
  logic [3:0] m_dem;
  logic       m_st, m_amb;

  always @(posedge Clk) begin
    int   ns, np;
    logic other, chg;
    obs_t e;
    if (reset) begin
      m_state = 0; m_phase = 0; m_timer = 0; m_dem = 4'b0; m_st = 1'b1; m_amb = 1'b0;
    end else begin
      ns = m_state;
      np = m_phase;
      other = 1'b0;
      for (int i = 0; i < NUM_APP; i++) if (i != m_phase && m_dem[i]) other = 1'b1;
      if (m_state == 0) begin
        if (amb_req && int'(amb_dir) != m_phase) ns = 1;
        else if (!amb_req && other && (m_timer >= GREEN_MIN || m_timer >= GREEN_MAX)) ns = 1;
      end else if (m_state == 1) begin
        if (m_timer == YELLOW_T) ns = 2;
      end else if (m_timer == ALLRED_T) begin
        ns = 0;
        if (amb_req) np = int'(amb_dir);
        else begin
          np = (m_phase + 1) % NUM_APP;
          for (int k = 1; k < NUM_APP; k++) begin
            if (m_dem[(m_phase + k) % NUM_APP]) begin
              np = (m_phase + k) % NUM_APP;
              break;
            end
          end
        end
      end
      for (int i = 0; i < NUM_APP; i++)
        if (car_det[i] && !(m_state == 0 && i == m_phase)) m_dem[i] = 1'b1;
      if (ns == 0 && m_state != 0) m_dem[np] = 1'b0;
      chg = (ns != m_state) || (np != m_phase);
      if (chg) m_timer = 0;
      else if (tick && m_timer < 255) m_timer = m_timer + 1;
      m_amb   = (ns == 0) && amb_req && (int'(amb_dir) == np);
      m_st    = chg;
      m_state = ns;
      m_phase = np;
    end
    e.green  = (m_state == 0) ? (4'b0001 << m_phase) : 4'b0000;
    e.yellow = (m_state == 1) ? (4'b0001 << m_phase) : 4'b0000;
    e.red    = ~(e.green | e.yellow);
    e.phase  = m_phase[1:0];
    e.st     = m_st;
    e.amb    = m_amb;
    exp_q.push_back(e);
  end

  always @(negedge Clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lamps", {red, yellow, green}, {e.red, e.yellow, e.green});
      check("phase", phase, e.phase);
      check("st", st, e.st);
      check("amb_active", amb_active, e.amb);
      check("one_lamp_each", {(red & yellow) | (red & green) | (yellow & green), red | yellow | green},
            {4'h0, 4'hF});
    end
  end

  task automatic do_reset();
    car_det = 4'b0;
    amb_req = 1'b0;
    amb_dir = 2'd0;
    reset   = 1'b1;
    repeat (2) @(negedge Clk);
    reset   = 1'b0;
  endtask

  task automatic pulse_car(input logic [3:0] v);
    car_det = v;
    @(negedge Clk);
    car_det = 4'b0;
  endtask

  task automatic wait_lamp(input string tag, input logic [3:0] g, input logic [3:0] y, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (green == g && yellow == y) break;
    end
    check(tag, {yellow, green}, {y, g});
  endtask

  initial begin
    int n, bad;
    reset = 1'b1; tick = 1'b1; car_det = 4'b0; amb_req = 1'b0; amb_dir = 2'd0;
    repeat (3) @(negedge Clk);
    reset = 1'b0;

    // Idle after reset: green on approach 0 held, st only right after reset.
    check("st_after_reset", st, 1'b1);
    check("green_after_reset", {red, yellow, green}, {4'b1110, 4'b0000, 4'b0001});
    bad = 0;
    repeat (50) begin
      @(negedge Clk);
      if (green != 4'b0001 || st) bad++;
    end
    check("idle_hold", bad, 0);

    // Long idle to push the timer into saturation, then demand must still be served promptly.
    repeat (205) @(negedge Clk);
    pulse_car(4'b0010);
    wait_lamp("sat_yellow", 4'b0000, 4'b0001, 4);
    wait_lamp("sat_serve", 4'b0010, 4'b0000, 10);

    // Single demand on approach 2 with exact yellow/green latencies.
    do_reset();
    car_det = 4'b0100;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      car_det = 4'b0;
      n++;
      if (yellow == 4'b0001) break;
    end
    check("yellow_latency", n, 4);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      n++;
      if (green == 4'b0100) break;
    end
    check("green2_latency", n, 9);
    check("green2_phase", phase, 2'd2);

    // Round-robin 1 -> 3 -> wrap to 0.
    do_reset();
    pulse_car(4'b1010);
    wait_lamp("rr_first", 4'b0010, 4'b0000, 30);
    wait_lamp("rr_second", 4'b1000, 4'b0000, 30);
    pulse_car(4'b0001);
    wait_lamp("rr_wrap", 4'b0001, 4'b0000, 30);

    // Preemption to approach 3 from green 0 at timer 0.
    do_reset();
    amb_req = 1'b1;
    amb_dir = 2'd3;
    @(negedge Clk);
    check("amb_immediate_yellow", yellow, 4'b0001);
    wait_lamp("amb_green", 4'b1000, 4'b0000, 10);
    pulse_car(4'b0001);
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if (green != 4'b1000 || !amb_active) bad++;
    end
    check("amb_hold", bad, 0);
    amb_req = 1'b0;
    wait_lamp("after_amb", 4'b0001, 4'b0000, 20);

    // Preemption pulse inside yellow: clearance runs full length, round-robin wins.
    pulse_car(4'b0100);
    wait_lamp("pre5_yellow", 4'b0000, 4'b0001, 20);
    amb_req = 1'b1;
    amb_dir = 2'd3;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      amb_req = 1'b0;
      n++;
      if (green != 4'b0000) break;
    end
    check("clear_len", n, 5);
    check("amb5_green", green, 4'b0100);
    check("amb5_inactive", amb_active, 1'b0);

    // Reset in yellow of phase 2 with demand pending elsewhere.
    pulse_car(4'b1001);
    wait_lamp("pre6_yellow", 4'b0000, 4'b0100, 20);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    check("reset_mid_green", green, 4'b0001);
    check("reset_mid_phase", phase, 2'd0);
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if (green != 4'b0001) bad++;
    end
    check("demand_cleared", bad, 0);
    pulse_car(4'b0010);
    wait_lamp("post_reset_serve", 4'b0010, 4'b0000, 20);

    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
